// File: rtl/sdes_sbox_engine.sv
// rtl/sdes_sbox_engine.sv - programmable multi-table S-box lookup engine with registered stream output
module sdes_sbox_engine #(
    parameter int IN_W    = 4,
    parameter int OUT_W   = 2,
    parameter int NUM_BOX = 2,
    parameter int BOX_W   = (NUM_BOX > 1) ? $clog2(NUM_BOX) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [BOX_W-1:0] cfg_box,
    input  logic [IN_W-1:0]  cfg_idx,
    input  logic [OUT_W-1:0] cfg_data,
    output logic             cfg_err,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [BOX_W-1:0] in_box,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_err
);

    localparam int DEPTH = 1 << IN_W;

    logic [OUT_W-1:0] tbl [NUM_BOX][DEPTH];
    logic [IN_W-1:0]  rd_idx;
    logic [OUT_W-1:0] rd_data;
    logic             rd_hit;
    logic             wr_hit;
    logic             xfer;

    // Outer bits select the row, inner bits the column; table index is {row, col}.
    assign rd_idx   = {in_data[IN_W-1], in_data[0], in_data[IN_W-2:1]};
    assign in_ready = !out_valid || out_ready;
    assign xfer     = in_valid && in_ready;

    // Box decode by explicit compare so non-power-of-two NUM_BOX never reads past the array.
    always_comb begin
        rd_data = '0;
        rd_hit  = 1'b0;
        wr_hit  = 1'b0;
        for (int b = 0; b < NUM_BOX; b++) begin
            if (in_box == BOX_W'(b)) begin
                rd_hit  = 1'b1;
                rd_data = tbl[b][rd_idx];
            end
            if (cfg_box == BOX_W'(b)) begin
                wr_hit = 1'b1;
            end
        end
    end

    // The lookup samples rd_data before the table write lands, giving read-before-write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int b = 0; b < NUM_BOX; b++) begin
                for (int e = 0; e < DEPTH; e++) begin
                    tbl[b][e] <= '0;
                end
            end
            cfg_err   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
        end else begin
            if (cfg_we && wr_hit) begin
                for (int b = 0; b < NUM_BOX; b++) begin
                    if (cfg_box == BOX_W'(b)) begin
                        tbl[b][cfg_idx] <= cfg_data;
                    end
                end
            end
            cfg_err <= cfg_we && !wr_hit;

            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= rd_hit ? rd_data : '0;
                out_err   <= !rd_hit;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sdes_sbox_engine.sv
// tb/tb_sdes_sbox_engine.sv - scoreboard bench for sdes_sbox_engine with three tables
module tb_sdes_sbox_engine;

    localparam int IN_W    = 4;
    localparam int OUT_W   = 2;
    localparam int NUM_BOX = 3;
    localparam int BOX_W   = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cfg_we;
    logic [BOX_W-1:0] cfg_box;
    logic [IN_W-1:0]  cfg_idx;
    logic [OUT_W-1:0] cfg_data;
    logic             cfg_err;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic [BOX_W-1:0] in_box;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_err;

    int checks   = 0;
    int failures = 0;

    logic [2:0] sb [$];

    sdes_sbox_engine #(
        .IN_W(IN_W),
        .OUT_W(OUT_W),
        .NUM_BOX(NUM_BOX)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .cfg_we(cfg_we),
        .cfg_box(cfg_box),
        .cfg_idx(cfg_idx),
        .cfg_data(cfg_data),
        .cfg_err(cfg_err),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .in_box(in_box),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Every result consumed downstream must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_result", {29'd0, out_err, out_data}, 32'hdead);
            end else begin
                check("sb_result", {29'd0, out_err, out_data}, {29'd0, sb.pop_front()});
            end
        end
    end

    task automatic wr(input logic [BOX_W-1:0] box, input logic [IN_W-1:0] idx,
                      input logic [OUT_W-1:0] data);
        cfg_we   = 1'b1;
        cfg_box  = box;
        cfg_idx  = idx;
        cfg_data = data;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic send(input logic [BOX_W-1:0] box, input logic [IN_W-1:0] data,
                        input logic err, input logic [OUT_W-1:0] exp);
        logic accepted;
        accepted = 1'b0;
        in_box   = box;
        in_data  = data;
        in_valid = 1'b1;
        sb.push_back({err, exp});
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(negedge clk);
            accepted = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!accepted) check("send_timeout", 32'd0, 32'd1);
    endtask

    int s0 [16] = '{1, 0, 3, 2, 3, 2, 1, 0, 0, 2, 1, 3, 3, 1, 3, 2};
    int s1 [16] = '{0, 1, 2, 3, 2, 0, 1, 3, 3, 0, 1, 0, 2, 1, 0, 3};

    initial begin
        rst_n     = 1'b0;
        cfg_we    = 1'b0;
        cfg_box   = '0;
        cfg_idx   = '0;
        cfg_data  = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_box    = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {30'd0, out_data}, 32'd0);
        check("rst_out_err", {31'd0, out_err}, 32'd0);
        check("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        send(2'd0, 4'b0110, 1'b0, 2'b00);
        check("first_latency_valid", {31'd0, out_valid}, 32'd1);
        check("first_data", {30'd0, out_data}, 32'd0);

        for (int i = 0; i < 16; i++) wr(2'd0, IN_W'(i), OUT_W'(s0[i]));
        check("valid_write_no_err", {31'd0, cfg_err}, 32'd0);
        for (int i = 0; i < 16; i++) wr(2'd1, IN_W'(i), OUT_W'(s1[i]));

        send(2'd0, 4'b0100, 1'b0, 2'b11);
        send(2'd0, 4'b0001, 1'b0, 2'b11);
        send(2'd0, 4'b1111, 1'b0, 2'b10);
        send(2'd0, 4'b1010, 1'b0, 2'b10);

        send(2'd1, 4'b0000, 1'b0, 2'b00);
        check("b2b_0", {29'd0, out_valid, out_data}, {29'd0, 3'b100});
        send(2'd1, 4'b1001, 1'b0, 2'b10);
        check("b2b_1", {29'd0, out_valid, out_data}, {29'd0, 3'b110});
        send(2'd1, 4'b0111, 1'b0, 2'b11);
        check("b2b_2", {29'd0, out_valid, out_data}, {29'd0, 3'b111});
        @(posedge clk);
        #1;

        out_ready = 1'b0;
        send(2'd0, 4'b0100, 1'b0, 2'b11);
        in_box   = 2'd1;
        in_data  = 4'b1001;
        in_valid = 1'b1;
        sb.push_back({1'b0, 2'b10});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_hold", {29'd0, out_valid, out_data}, {29'd0, 3'b111});
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_release", {29'd0, out_valid, out_data}, {29'd0, 3'b110});
        @(posedge clk);
        #1;

        cfg_we   = 1'b1;
        cfg_box  = 2'd0;
        cfg_idx  = 4'd0;
        cfg_data = 2'b10;
        send(2'd0, 4'b0000, 1'b0, 2'b01);
        cfg_we = 1'b0;
        check("rbw_old", {30'd0, out_data}, 32'd1);
        send(2'd0, 4'b0000, 1'b0, 2'b10);
        check("rbw_new", {30'd0, out_data}, 32'd2);

        wr(2'd3, 4'd0, 2'b11);
        check("cfg_err_pulse", {31'd0, cfg_err}, 32'd1);
        @(posedge clk);
        #1;
        check("cfg_err_clear", {31'd0, cfg_err}, 32'd0);
        send(2'd2, 4'b0000, 1'b0, 2'b00);
        send(2'd0, 4'b0000, 1'b0, 2'b10);
        send(2'd1, 4'b0000, 1'b0, 2'b00);
        send(2'd3, 4'b0100, 1'b1, 2'b00);
        check("oob_lookup", {29'd0, out_err, out_data}, {29'd0, 3'b100});
        @(posedge clk);
        #1;

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
        check("sb_drained", sb.size(), 32'd0);

        out_ready = 1'b0;
        send(2'd0, 4'b0100, 1'b0, 2'b11);
        void'(sb.pop_back());
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midreset_discard", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        send(2'd0, 4'b0100, 1'b0, 2'b00);
        check("reset_clears_table", {30'd0, out_data}, 32'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        check("sb_final_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
